packet_router_n: RTL
====================

// Module: packet_router_n
// PURPOSE
//  N-port successor of the 4-port switch. Buffers an incoming word stream in an internal FWFT FIFO,
//  parses packets (DA, SA, LEN, LEN payload words), matches DA against a programmable per-port
//  address table and forwards the whole packet to one output port under per-word read backpressure.
//  Unmatched and timed-out packets are flushed and counted. Sits between the ingress stream and
//  the port consumers.
// PARAMETERS
//  NUM_PORTS   4     output ports (2..16); AW = $clog2(NUM_PORTS)
//  DATA_W      8     word width; also width of DA/SA/LEN fields
//  FIFO_DEPTH  1024  input FIFO words, power of 2
//  TIMEOUT     255   max AWAIT cycles before the packet is dropped; 0 = wait forever
// PORTS
//  clk          in  1               rising-edge clock
//  reset        in  1               synchronous, active-high
//  data         in  DATA_W          ingress word
//  data_status  in  1               ingress valid; word written if !fifo_full
//  fifo_full    out 1               FIFO holds FIFO_DEPTH words
//  fifo_ovf     out 1               sticky: write attempted while full; cleared only by reset
//  mem_en       in  1               config access strobe
//  mem_rd_wr    in  1               1 = write table, 0 = read table
//  mem_add      in  AW              table index (port number)
//  mem_data     in  DATA_W          table write data
//  mem_rdata    out DATA_W          read data, registered, valid 1 cycle after a read strobe
//  port_data    out NUM_PORTS*DATA_W  port p at [p*DATA_W +: DATA_W]
//  ready        out NUM_PORTS       per-port packet-pending / transfer-active
//  read         in  NUM_PORTS       per-port accept
//  drop_count   out 16              packets dropped (saturates at 16'hFFFF)
//  busy         out 1               FSM not in IDLE
// BEHAVIOUR
//  Clock clk; reset synchronous, active-high: FSM->IDLE, FIFO emptied, table all ones,
//   port_data/ready/mem_rdata/drop_count/fifo_ovf/busy/fifo_full = 0. Reset mid-packet discards it.
//  FIFO: FWFT, head visible when !empty. Write blocked when full even if pop same cycle (full is
//   registered); pop when empty ignored. Only the FSM pops.
//  Table: write takes effect next cycle; never alters a packet already past IDLE. Duplicate
//   entries: lowest index wins. Reset value all ones => DA=all-ones goes to port 0 by default.
//  FSM states IDLE, AWAIT, FORWARD, DROP. Word index widx (DATA_W+2 bits), len_q (DATA_W).
//   IDLE: if !empty, compare head (DA) with all entries. Match -> sel<=idx, ready[sel]<=1,
//     wait_cnt<=0, AWAIT. No match -> DROP, drop_count++. Nothing popped in IDLE.
//   AWAIT: read[sel]=1 -> FORWARD (no transfer this cycle). Else wait_cnt++; if TIMEOUT!=0 and
//     wait_cnt==TIMEOUT-1 -> ready[sel]<=0, drop_count++, DROP.
//   FORWARD: ready[sel] held 1. port_data[sel]=head when !empty, else 0; other ports always 0.
//     Transfer (pop) in any cycle with !empty && read[sel]; stall otherwise, no data lost.
//     widx increments per transfer; at widx==2 len_q<=head.
//     Last word: widx==2 && head==0, or widx>2 && widx==len_q+2. After the last transfer -> IDLE,
//     ready[sel]<=0, widx<=0; next packet may start the following cycle.
//   DROP: pop every cycle with !empty, same widx/len counting, no port output, ready all 0;
//     after the last word -> IDLE.
//  Packet length = LEN+3 words; LEN=0 is legal (3 words). Max LEN = 2^DATA_W-1.
//  Throughput: 1 word/cycle in FORWARD with read held high; IDLE->AWAIT costs 1 cycle,
//   AWAIT->FORWARD at least 1 cycle.
//  drop_count saturates; never wraps.
// TESTING
//  1 Table {0x11,0x22,0x33,0x44}; send DA=0x33,SA=0x01,LEN=4,+4 words, read[2] held 1 ->
//    ready[2] rises, 7 words appear in order on port 2 only, ready[2] falls, drop_count=0.
//  2 DA=0x99 (no match), LEN=2 -> all 5 words flushed, no ready, drop_count=1, FIFO empty.
//  3 TIMEOUT=8, match port 1, read never asserted -> ready[1] high 8 cycles then low, packet
//    flushed, drop_count=1; next valid packet then forwards normally.
//  4 FORWARD with read[0] toggled every other cycle -> words held stable on stall, no loss/dup;
//    LEN=0 packet -> exactly 3 words.
//  5 Fill FIFO_DEPTH words, write one more -> fifo_full=1, fifo_ovf=1, extra word lost.
//  6 Write table[3]=0x55, read it back -> mem_rdata=0x55 one cycle later; reset mid-FORWARD ->
//    all outputs 0, table all ones, FIFO empty.

Source files
------------

// File: rtl/packet_router_n.sv
// packet_router_n: buffers an ingress word stream in a FWFT FIFO, parses DA/SA/LEN packets,
// routes each whole packet to the port whose table entry matches DA, and flushes/counts the rest.
//   clk, reset            clock, synchronous active-high reset
//   i_data/i_data_status  ingress word and valid; o_fifo_full, o_fifo_ovf (sticky) report FIFO state
//   i_mem_*/o_mem_rdata   address-table write/read access, read data one cycle after the strobe
//   o_port_data/o_ready   per-port word and packet-pending flag; i_read per-port accept
//   o_drop_count          saturating dropped-packet count; o_busy high whenever a packet is in flight
module packet_router_n #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 1024,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_status,
    output logic                          o_fifo_full,
    output logic                          o_fifo_ovf,
    input  logic                          i_mem_en,
    input  logic                          i_mem_rd_wr,
    input  logic [$clog2(NUM_PORTS)-1:0]  i_mem_add,
    input  logic [DATA_W-1:0]             i_mem_data,
    output logic [DATA_W-1:0]             o_mem_rdata,
    output logic [NUM_PORTS*DATA_W-1:0]   o_port_data,
    output logic [NUM_PORTS-1:0]          o_ready,
    input  logic [NUM_PORTS-1:0]          i_read,
    output logic [15:0]                   o_drop_count,
    output logic                          o_busy
);
    localparam int AW  = $clog2(NUM_PORTS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int WW  = DATA_W + 2;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, AWAIT, FORWARD, DROP} state_t;
    state_t r_state, w_state_nx;

    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [DATA_W-1:0] r_tab [NUM_PORTS];
    logic [FAW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [FAW:0]      r_cnt;
    logic [AW-1:0]     r_sel, w_idx;
    logic [TW-1:0]     r_wait;
    logic [WW-1:0]     r_widx;
    logic [DATA_W-1:0] r_len, r_mem_rdata, w_head;
    logic [15:0]       r_drop;
    logic              r_ovf, w_empty, w_full, w_wr, w_pop, w_hit, w_last, w_drop_inc;

    assign w_empty = r_cnt == '0;
    assign w_full  = r_cnt == (FAW+1)'(FIFO_DEPTH);
    assign w_wr    = i_data_status && !w_full;
    assign w_head  = r_fifo[r_rd_ptr];
    // word index 2 carries LEN; a zero LEN ends the packet right there
    assign w_last  = (r_widx == WW'(2) && w_head == '0) ||
                     (r_widx > WW'(2) && r_widx == {2'b00, r_len} + WW'(2));
    assign w_drop_inc = (r_state == IDLE && !w_empty && !w_hit) ||
                        (r_state == AWAIT && w_state_nx == DROP);

    always_ff @(posedge clk)
        if (w_wr) r_fifo[r_wr_ptr] <= i_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + FAW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + FAW'(1);
            r_cnt <= r_cnt + (FAW+1)'(w_wr) - (FAW+1)'(w_pop);
            if (i_data_status && w_full) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) r_tab[p] <= '1;
            r_mem_rdata <= '0;
        end else if (i_mem_en && int'(i_mem_add) < NUM_PORTS) begin
            if (i_mem_rd_wr) r_tab[i_mem_add] <= i_mem_data;
            else r_mem_rdata <= r_tab[i_mem_add];
        end
    end

    // descending scan so the lowest matching index is the one that sticks
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            if (r_tab[p] == w_head) begin
                w_hit = 1'b1;
                w_idx = AW'(p);
            end
    end

    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_state_nx;

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            IDLE:    if (!w_empty) w_state_nx = w_hit ? AWAIT : DROP;
            AWAIT:   w_state_nx = i_read[r_sel] ? FORWARD :
                                  (TIMEOUT != 0 && r_wait == TO_LAST) ? DROP : AWAIT;
            FORWARD: begin
                w_pop      = !w_empty && i_read[r_sel];
                w_state_nx = (w_pop && w_last) ? IDLE : FORWARD;
            end
            default: begin
                w_pop      = !w_empty;
                w_state_nx = (w_pop && w_last) ? IDLE : DROP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel  <= '0;
            r_wait <= '0;
            r_widx <= '0;
            r_len  <= '0;
            r_drop <= '0;
        end else begin
            if (r_state == IDLE && !w_empty) begin
                r_sel  <= w_idx;
                r_wait <= '0;
            end
            if (r_state == AWAIT) r_wait <= r_wait + TW'(1);
            if (w_pop) begin
                r_widx <= w_last ? '0 : r_widx + WW'(1);
                if (r_widx == WW'(2)) r_len <= w_head;
            end
            if (w_drop_inc && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
        end
    end

    always_comb begin
        o_ready     = '0;
        o_port_data = '0;
        if (r_state == AWAIT || r_state == FORWARD) o_ready[r_sel] = 1'b1;
        if (r_state == FORWARD && !w_empty) o_port_data[r_sel*DATA_W +: DATA_W] = w_head;
    end

    assign o_busy       = r_state != IDLE;
    assign o_drop_count = r_drop;
    assign o_fifo_full  = w_full;
    assign o_fifo_ovf   = r_ovf;
    assign o_mem_rdata  = r_mem_rdata;
endmodule
